// File: rtl/smi_frame_arbiter_x3.sv
// Purpose : merges three SMI flit inputs (A, B, C) into one output, round-robin
//           per frame, never interleaving flits of different frames.
// Latency : one cycle from input acceptance to smiOutReady; one flit per cycle.
// Backpr. : granted input's Stop follows the stalled output register; any other
//           input is stopped whenever it presents a flit.
// Ports   : clk/nrst (async active-low); smiIn{A,B,C}{Ready,Eofc,Data} in,
//           smiIn{A,B,C}Stop out; smiOut{Ready,Eofc,Data} out, smiOutStop in.
// Option  : define SMI_FRAME_ARB_COUNT_EN to add 16-bit completed-frame
//           counters frameCountA/B/C.
module smi_frame_arbiter_x3 #(
  parameter int FlitWidth = 16,
  parameter int EofcMask  = 2*FlitWidth-1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   smiInAReady,
  input  logic [7:0]             smiInAEofc,
  input  logic [FlitWidth*8-1:0] smiInAData,
  output logic                   smiInAStop,
  input  logic                   smiInBReady,
  input  logic [7:0]             smiInBEofc,
  input  logic [FlitWidth*8-1:0] smiInBData,
  output logic                   smiInBStop,
  input  logic                   smiInCReady,
  input  logic [7:0]             smiInCEofc,
  input  logic [FlitWidth*8-1:0] smiInCData,
  output logic                   smiInCStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
`ifdef SMI_FRAME_ARB_COUNT_EN
  ,
  output logic [15:0]            frameCountA,
  output logic [15:0]            frameCountB,
  output logic [15:0]            frameCountC
`endif
);

  localparam int         DataW     = FlitWidth*8;
  localparam logic [7:0] EofcMask8 = 8'(EofcMask);

  if (FlitWidth < 4) begin : g_bad_width
    $error("smi_frame_arbiter_x3: FlitWidth must be at least 4");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  // Input indices: A = 0, B = 1, C = 2.
  state_t             state_q;
  logic [1:0]         grant_q;
  logic [1:0]         last_q;

  logic [2:0]         req;
  logic [7:0]         eofc_in [3];
  logic [DataW-1:0]   data_in [3];

  logic [1:0]         pick;
  logic               pick_vld;
  logic [1:0]         sel;
  logic               sel_vld;
  logic               out_hold;
  logic               load;
  logic               accept;
  logic               last_flit;
  logic [2:0]         stop;

  assign req        = {smiInCReady, smiInBReady, smiInAReady};
  assign eofc_in[0] = smiInAEofc;
  assign eofc_in[1] = smiInBEofc;
  assign eofc_in[2] = smiInCEofc;
  assign data_in[0] = smiInAData;
  assign data_in[1] = smiInBData;
  assign data_in[2] = smiInCData;

  // Input index 'step' positions after 'base' in the cyclic order A, B, C.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Round-robin pick: scan starting just after the last-granted input.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      if (!pick_vld && req[rr_idx(last_q, 2'(i))]) begin
        pick_vld = 1'b1;
        pick     = rr_idx(last_q, 2'(i));
      end
    end
  end

  // In IDLE the pick is served in the same cycle (zero-bubble); in LOCKED
  // only the owner of the open frame may move.
  assign sel       = (state_q == LOCKED) ? grant_q : pick;
  assign sel_vld   = (state_q == LOCKED) | pick_vld;
  assign out_hold  = smiOutReady & smiOutStop;
  assign load      = ~out_hold;
  assign accept    = sel_vld & req[sel] & load;
  // End of frame is decided on the raw Eofc, before masking.
  assign last_flit = |eofc_in[sel];

  // Stops are forced low during reset so no source sees a stall while the
  // block is held.
  always_comb begin
    stop = 3'b000;
    for (int x = 0; x < 3; x++) begin
      if (sel_vld && (sel == 2'(x))) stop[x] = nrst & out_hold;
      else                           stop[x] = nrst & req[x];
    end
  end

  assign smiInAStop = stop[0];
  assign smiInBStop = stop[1];
  assign smiInCStop = stop[2];

  // Arbitration FSM together with the output control register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      last_q      <= 2'd2;   // C, so A is first after reset
      smiOutReady <= 1'b0;
      smiOutEofc  <= 8'h00;
    end else begin
      if (load) begin
        // With nothing accepted the register reloads empty, so a flit that
        // has already left is never shown twice.
        smiOutReady <= accept;
        if (accept) smiOutEofc <= eofc_in[sel] & EofcMask8;
      end
      if (accept) begin
        if (last_flit) begin
          state_q <= IDLE;
          last_q  <= sel;
        end else begin
          state_q <= LOCKED;
          grant_q <= sel;
        end
      end
    end
  end

  // Payload register carries no reset.
  always_ff @(posedge clk) begin
    if (accept) smiOutData <= data_in[sel];
  end

`ifdef SMI_FRAME_ARB_COUNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frameCountA <= 16'h0000;
      frameCountB <= 16'h0000;
      frameCountC <= 16'h0000;
    end else if (accept && last_flit) begin
      case (sel)
        2'd0:    frameCountA <= frameCountA + 16'd1;
        2'd1:    frameCountB <= frameCountB + 16'd1;
        default: frameCountC <= frameCountC + 16'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_smi_frame_arbiter_x3.sv
module tb_smi_frame_arbiter_x3;
  localparam int         FW   = 16;
  localparam int         DW   = FW*8;
  localparam logic [7:0] MASK = 8'h1F;  // default EofcMask = 2*16-1

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          smiInAReady, smiInBReady, smiInCReady;
  logic [7:0]    smiInAEofc, smiInBEofc, smiInCEofc;
  logic [DW-1:0] smiInAData, smiInBData, smiInCData;
  logic          smiInAStop, smiInBStop, smiInCStop;
  logic          smiOutReady;
  logic [7:0]    smiOutEofc;
  logic [DW-1:0] smiOutData;
  logic          smiOutStop = 1'b0;
`ifdef SMI_FRAME_ARB_COUNT_EN
  logic [15:0]   frameCountA, frameCountB, frameCountC;
`endif

  smi_frame_arbiter_x3 dut (
    .clk(clk), .nrst(nrst),
    .smiInAReady(smiInAReady), .smiInAEofc(smiInAEofc), .smiInAData(smiInAData), .smiInAStop(smiInAStop),
    .smiInBReady(smiInBReady), .smiInBEofc(smiInBEofc), .smiInBData(smiInBData), .smiInBStop(smiInBStop),
    .smiInCReady(smiInCReady), .smiInCEofc(smiInCEofc), .smiInCData(smiInCData), .smiInCStop(smiInCStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData),
    .smiOutStop(smiOutStop)
`ifdef SMI_FRAME_ARB_COUNT_EN
    , .frameCountA(frameCountA), .frameCountB(frameCountB), .frameCountC(frameCountC)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Source queues: {eofc, 16-bit flit id}; the id is carried in Data[15:0].
  logic [23:0] qa[$], qb[$], qc[$];
  // Output transfer log and the hand-written expectation for it.
  logic [15:0] log_id[$];
  logic [7:0]  log_ef[$];
  int          log_cyc[$];
  logic [15:0] want_id[$];
  logic [7:0]  want_ef[$];

  logic [2:0]  xfer = 3'b000;
  logic        a_stop_seen = 1'b0;

  // Stream-level model: who owns the output, who was last granted, and
  // what the output register must show.
  int            owner = -1;
  int            last_g = 2;
  logic          exp_vld = 1'b0;
  logic [7:0]    exp_ef = 8'h00;
  logic [DW-1:0] exp_dat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Compare process, once per cycle on the falling edge.
  always @(negedge clk) begin
    logic [2:0] r, s, s_exp;
    logic       load, acc;
    logic [7:0] ef_g;
    logic [DW-1:0] dt_g;
    int g;
    r = {smiInCReady, smiInBReady, smiInAReady};
    s = {smiInCStop, smiInBStop, smiInAStop};
    if (!nrst) begin
      chk("reset_out", 64'({smiOutReady, smiOutEofc}), 64'd0);
      chk("reset_stop", 64'(s), 64'd0);
      owner = -1; last_g = 2; exp_vld = 1'b0; xfer = 3'b000;
    end else begin
      if (exp_vld)
        chk("out_flit", {39'b0, smiOutReady, smiOutEofc, smiOutData[15:0]},
                        {39'b0, 1'b1, exp_ef, exp_dat[15:0]});
      else
        chk("out_idle", 64'(smiOutReady), 64'd0);

      g = -1;
      if (owner >= 0) g = owner;
      else for (int k = 1; k <= 3; k++) if (g < 0 && r[(last_g + k) % 3]) g = (last_g + k) % 3;

      load = !(exp_vld && smiOutStop);
      for (int x = 0; x < 3; x++) s_exp[x] = (x == g) ? (exp_vld && smiOutStop) : r[x];
      chk("in_stop", 64'(s), 64'(s_exp));
      if (s[0]) a_stop_seen = 1'b1;
      xfer = r & ~s;

      if (smiOutReady && !smiOutStop) begin
        log_id.push_back(smiOutData[15:0]);
        log_ef.push_back(smiOutEofc);
        log_cyc.push_back(cyc);
      end

      acc  = (g >= 0) && r[g] && load;
      ef_g = (g == 0) ? smiInAEofc : (g == 1) ? smiInBEofc : smiInCEofc;
      dt_g = (g == 0) ? smiInAData : (g == 1) ? smiInBData : smiInCData;
      if (load) begin
        exp_vld = acc;
        if (acc) begin exp_ef = ef_g & MASK; exp_dat = dt_g; end
      end
      if (acc) begin
        if (ef_g != 8'h00) begin owner = -1; last_g = g; end
        else owner = g;
      end
    end
  end

  // Source driver: pops a head that transferred, then presents the next.
  initial begin
    smiInAReady = 0; smiInAEofc = 0; smiInAData = '0;
    smiInBReady = 0; smiInBEofc = 0; smiInBData = '0;
    smiInCReady = 0; smiInCEofc = 0; smiInCData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (nrst && xfer[0] && qa.size() > 0) qa.delete(0);
      if (nrst && xfer[1] && qb.size() > 0) qb.delete(0);
      if (nrst && xfer[2] && qc.size() > 0) qc.delete(0);
      smiInAReady = (qa.size() > 0); smiInAEofc = 8'h00; smiInAData = '0;
      if (qa.size() > 0) begin smiInAEofc = qa[0][23:16]; smiInAData[15:0] = qa[0][15:0]; end
      smiInBReady = (qb.size() > 0); smiInBEofc = 8'h00; smiInBData = '0;
      if (qb.size() > 0) begin smiInBEofc = qb[0][23:16]; smiInBData[15:0] = qb[0][15:0]; end
      smiInCReady = (qc.size() > 0); smiInCEofc = 8'h00; smiInCData = '0;
      if (qc.size() > 0) begin smiInCEofc = qc[0][23:16]; smiInCData[15:0] = qc[0][15:0]; end
    end
  end

  task automatic push(input int src, input logic [15:0] id, input logic [7:0] ef);
    case (src)
      0:       qa.push_back({ef, id});
      1:       qb.push_back({ef, id});
      default: qc.push_back({ef, id});
    endcase
  endtask

  task automatic want(input logic [15:0] id, input logic [7:0] ef);
    want_id.push_back(id);
    want_ef.push_back(ef);
  endtask

  task automatic clear_log();
    log_id.delete(); log_ef.delete(); log_cyc.delete();
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, 64'(log_id.size()), 64'(want_id.size()));
    for (int i = 0; i < want_id.size() && i < log_id.size(); i++)
      chk(name, {40'b0, log_ef[i], log_id[i]}, {40'b0, want_ef[i], want_id[i]});
    want_id.delete(); want_ef.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int  n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      busy = (qa.size() + qb.size() + qc.size() != 0) || smiInAReady || smiInBReady ||
             smiInCReady || smiOutReady;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_timeout cycles=%0d limit=%0d", name, n, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 nrst = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
    clear_log();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 nrst = 1'b1;

    // Single 3-flit frame on A, one-cycle latency, A never stopped.
    clear_log();
    a_stop_seen = 1'b0;
    @(posedge clk);
    push(0, 16'hA10, 8'h00); push(0, 16'hA11, 8'h00); push(0, 16'hA12, 8'h10);
    @(negedge clk);
    chk("t1_before_accept", 64'(smiOutReady), 64'd0);
    @(negedge clk);
    chk("t1_first_out", {47'b0, smiOutReady, smiOutData[15:0]}, {47'b0, 1'b1, 16'hA10});
    wait_idle("t1", 50);
    want(16'hA10, 8'h00); want(16'hA11, 8'h00); want(16'hA12, 8'h10);
    check_log("t1_log");
    chk("t1_a_stop_seen", 64'(a_stop_seen), 64'd0);

    // Three simultaneous 2-flit frames after reset: A, B, C, back to back.
    do_reset();
    @(posedge clk);
    push(0, 16'hA20, 8'h00); push(0, 16'hA21, 8'h01);
    push(1, 16'hB20, 8'h00); push(1, 16'hB21, 8'h02);
    push(2, 16'hC20, 8'h00); push(2, 16'hC21, 8'h21);
    wait_idle("t2", 50);
    want(16'hA20, 8'h00); want(16'hA21, 8'h01);
    want(16'hB20, 8'h00); want(16'hB21, 8'h02);
    want(16'hC20, 8'h00); want(16'hC21, 8'h01);   // 0x21 masked by 0x1F
    if (log_cyc.size() == 6) chk("t2_no_gap", 64'(log_cyc[5] - log_cyc[0]), 64'd5);
    check_log("t2_log");

    // B arrives mid-way through A's 4-flit frame and must wait.
    clear_log();
    @(posedge clk);
    push(0, 16'hA30, 8'h00); push(0, 16'hA31, 8'h00);
    push(0, 16'hA32, 8'h00); push(0, 16'hA33, 8'h04);
    repeat (2) @(posedge clk);
    push(1, 16'hB30, 8'h00); push(1, 16'hB31, 8'h06);
    wait_idle("t3", 50);
    if (log_cyc.size() == 6) chk("t3_b_follows", 64'(log_cyc[4] - log_cyc[3]), 64'd1);
    want(16'hA30, 8'h00); want(16'hA31, 8'h00); want(16'hA32, 8'h00); want(16'hA33, 8'h04);
    want(16'hB30, 8'h00); want(16'hB31, 8'h06);
    check_log("t3_log");

    // Five-cycle output stall in the middle of a C frame.
    clear_log();
    @(posedge clk);
    push(2, 16'hC40, 8'h00); push(2, 16'hC41, 8'h00);
    push(2, 16'hC42, 8'h00); push(2, 16'hC43, 8'h08);
    repeat (2) @(posedge clk);
    #2 smiOutStop = 1'b1;
    @(negedge clk);
    chk("t4_c_stopped", 64'(smiInCStop), 64'd1);
    chk("t4_out_held", {47'b0, smiOutReady, smiOutData[15:0]}, {47'b0, 1'b1, 16'hC41});
    repeat (5) @(posedge clk);
    #2 smiOutStop = 1'b0;
    wait_idle("t4", 50);
    want(16'hC40, 8'h00); want(16'hC41, 8'h00); want(16'hC42, 8'h00); want(16'hC43, 8'h08);
    check_log("t4_log");

    // Asynchronous reset mid-frame of C; then A and C together, A wins.
    clear_log();
    @(posedge clk);
    push(2, 16'hC50, 8'h00); push(2, 16'hC51, 8'h00);
    push(2, 16'hC52, 8'h00); push(2, 16'hC53, 8'h0C);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t5_async_out", 64'({smiOutReady, smiOutEofc}), 64'd0);
    chk("t5_async_stop", 64'({smiInAStop, smiInBStop, smiInCStop}), 64'd0);
    qa.delete(); qb.delete(); qc.delete();
    clear_log();
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
    @(posedge clk);
    push(0, 16'hA50, 8'h03);
    push(2, 16'hC60, 8'h05);
    wait_idle("t5", 50);
    want(16'hA50, 8'h03); want(16'hC60, 8'h05);
    check_log("t5_log");

`ifdef SMI_FRAME_ARB_COUNT_EN
    // 65537 single-flit frames on A: counter wraps once and lands on 1.
    do_reset();
    @(posedge clk);
    for (int i = 0; i < 65537; i++) push(0, 16'(i), 8'h01);
    wait_idle("t6", 70000);
    chk("t6_count_a", 64'(frameCountA), 64'd1);
    chk("t6_count_b", 64'(frameCountB), 64'd0);
    chk("t6_count_c", 64'(frameCountC), 64'd0);
    clear_log();
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
